// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared constants and FSM state type for the vote result link
package vote_pkg;

  localparam int NUM_VOTERS      = 8;
  localparam int COUNT_W         = 4;
  localparam int FRAME_BITS      = 16;
  localparam int PAYLOAD_BITS    = 13;
  localparam int MAJORITY_THRESH = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/vote_popcount.sv
// rtl/vote_popcount.sv - combinational ballot tally, shared with the receiver-side tally
module vote_popcount
  import vote_pkg::*;
(
  input  logic [NUM_VOTERS-1:0] votes,
  output logic [COUNT_W-1:0]    count,
  output logic                  majority
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      count = count + COUNT_W'(votes[i]);
    end
    // strict majority of eight, so a 4-4 split is not a majority
    majority = (count >= COUNT_W'(MAJORITY_THRESH));
  end

endmodule

// File: rtl/vote_result_tx.sv
// rtl/vote_result_tx.sv - latches a ballot and serialises mask/count/majority/parity on a UART-style line
module vote_result_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_VOTERS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VOTERS-1:0] votes_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [3:0]            count_o,
  output logic                  majority_o
);
  import vote_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t               state;
  tx_state_t               next_state;
  logic [CW-1:0]           cyc_cnt;
  logic [3:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] shift;
  logic                    parity;
  logic                    done;
  logic                    tx;
  logic                    cyc_last;
  logic                    accept;
  logic [COUNT_W-1:0]      tally;
  logic                    tally_maj;

  vote_popcount u_popcount (
    .votes    (votes_i),
    .count    (tally),
    .majority (tally_maj)
  );

  assign ready_o  = (state == IDLE);
  assign busy_o   = (state != IDLE);
  assign accept   = valid_i && ready_o;
  assign cyc_last = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
  // line is decoded from state so reset forces it high without waiting for a clock
  assign tx_o     = tx;
  assign done_o   = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx         = 1'b1;
    case (state)
      IDLE:   if (accept) next_state = START;
      START: begin
        tx = 1'b0;
        if (cyc_last) next_state = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (cyc_last && bit_cnt == 4'(PAYLOAD_BITS - 1)) next_state = PARITY;
      end
      PARITY: begin
        tx = parity;
        if (cyc_last) next_state = STOP;
      end
      STOP:   if (cyc_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      done       <= 1'b0;
      count_o    <= '0;
      majority_o <= 1'b0;
    end else begin
      done <= (state == STOP) && cyc_last;

      if (state == IDLE || cyc_last) cyc_cnt <= '0;
      else                           cyc_cnt <= cyc_cnt + 1'b1;

      if (next_state != state)            bit_cnt <= '0;
      else if (state == DATA && cyc_last) bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && cyc_last) shift <= shift >> 1;

      // payload is packed so that shifting right emits mask, count, majority LSB first
      if (accept) begin
        shift      <= {tally_maj, tally, votes_i};
        parity     <= ^{tally_maj, tally, votes_i};
        count_o    <= tally;
        majority_o <= tally_maj;
      end
    end
  end

endmodule

// File: tb/tb_vote_result_tx.sv
// tb/tb_vote_result_tx.sv - directed frame checks for vote_result_tx
module tb_vote_result_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] votes_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] count_o;
  logic       majority_o;

  int vectors     = 0;
  int miscompares = 0;

  vote_result_tx #(.CLKS_PER_BIT(CPB), .NUM_VOTERS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .votes_i    (votes_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .count_o    (count_o),
    .majority_o (majority_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered between a posedge and the next posedge; returns at the negedge of the done cycle.
  task automatic run_frame(input logic [7:0] v, input logic [3:0] c, input logic m,
                           input logic p, input logic hold);
    logic [15:0] fr;
    fr      = {1'b1, p, m, c, v, 1'b0};
    votes_i = v;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("count", 32'(count_o), 32'(c));
    check("majority", 32'(majority_o), 32'(m));
    check("busy_after_accept", 32'(busy_o), 32'd1);
    check("ready_after_accept", 32'(ready_o), 32'd0);
    if (!hold) valid_i = 1'b0;
    votes_i = ~v;
    for (int k = 1; k <= 16 * CPB; k++) begin
      @(negedge clk);
      check($sformatf("tx_c%0d", k), 32'(tx_o), 32'(fr[(k - 1) / CPB]));
      check($sformatf("done_c%0d", k), 32'(done_o), 32'd0);
      if (k == 30) votes_i = v ^ 8'h5A;
    end
    @(negedge clk);
    check("done_pulse", 32'(done_o), 32'd1);
    check("ready_done", 32'(ready_o), 32'd1);
    check("busy_done", 32'(busy_o), 32'd0);
    check("count_hold", 32'(count_o), 32'(c));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_majority", 32'(majority_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_tx", 32'(tx_o), 32'd1);
      check("idle_ready", 32'(ready_o), 32'd1);
    end

    run_frame(8'b1011_0001, 4'd4, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    run_frame(8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    run_frame(8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    run_frame(8'h1F, 4'd5, 1'b1, 1'b0, 1'b1);
    run_frame(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    votes_i = 8'hA5;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_tx_bit6", 32'(tx_o), 32'd0);
    check("pre_rst_count", 32'(count_o), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_o), 32'd1);
    check("async_rst_ready", 32'(ready_o), 32'd1);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_count", 32'(count_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'hA5, 4'd4, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    run_frame(8'h0F, 4'd4, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    run_frame(8'h1F, 4'd5, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
